// File: rtl/crossy_pkg.sv
// Shared definitions for the crossy game-flow blocks: state encoding,
// score width, default timing parameters and the frame counter width helper.
package crossy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int SCORE_W              = 7;
    localparam int DEBOUNCE_CYCLES_DEF  = 250000;
    localparam int HIT_FRAMES_DEF       = 60;

    // Width needed to count HIT frames from 0 up to HIT_FRAMES inclusive.
    function automatic int frame_cnt_w(input int hit_frames);
        return $clog2(hit_frames + 1);
    endfunction

endpackage

// File: rtl/game_ctrl_btn_debounce.sv
// Move-button conditioning: 2-flop synchronizer, stability counter and a
// one-cycle pulse on the rising edge of the accepted (stable) level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DB_W            = 18
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_stable;
    logic            r_stable_d;
    logic [DB_W-1:0] r_cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed from the stable level
    // for DEBOUNCE_CYCLES consecutive cycles; any return resets the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (r_sync2 == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Delayed copy of the stable level for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable_d <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
        end
    end

    assign o_press = r_stable & ~r_stable_d;

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: move-button conditioning, per-frame collision latch,
// IDLE/PLAY/HIT/OVER sequencing of reset/freeze/flash, and high-score tracking.
module game_ctrl
    import crossy_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DB_W            = 18,
    parameter int HIT_FRAMES      = HIT_FRAMES_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_move_btn,
    input  logic               i_collision,
    input  logic               i_frame_tick,
    input  logic [SCORE_W-1:0] i_score,
    output logic               o_move_pulse,
    output logic               o_game_rst,
    output logic               o_freeze,
    output logic               o_flash,
    output logic [1:0]         o_state,
    output logic [SCORE_W-1:0] o_high_score
);

    localparam int             FCW       = frame_cnt_w(HIT_FRAMES);
    localparam logic [FCW-1:0] FRM_LAST  = FCW'(HIT_FRAMES - 1);

    state_t             r_state;
    logic [FCW-1:0]     r_frame_cnt;
    logic               r_hit_seen;
    logic               r_move_pulse;
    logic               r_game_rst;
    logic               r_freeze;
    logic               r_flash;
    logic [SCORE_W-1:0] r_high_score;

    state_t             w_state_next;
    logic [FCW-1:0]     w_frame_cnt_next;
    logic [FCW-1:0]     w_cnt_inc;
    logic               w_flash_bit;
    logic               w_move_next;
    logic               w_rst_next;
    logic               w_freeze_next;
    logic               w_flash_next;
    logic [SCORE_W-1:0] w_high_score_next;
    logic               w_press;
    logic               w_hit_now;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) u_btn_debounce (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_move_btn),
        .o_press (w_press)
    );

    assign w_cnt_inc = r_frame_cnt + 1'b1;
    assign w_hit_now = i_frame_tick & (r_hit_seen | i_collision);

    // Flash follows bit 3 of the frame count; short HIT phases never reach it.
    generate
        if (FCW > 3) begin : g_flash_bit
            assign w_flash_bit = w_cnt_inc[3];
        end else begin : g_no_flash_bit
            assign w_flash_bit = 1'b0;
        end
    endgenerate

    // Remember any collision seen during the current PLAY frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hit_seen <= 1'b0;
        end else if (i_frame_tick) begin
            r_hit_seen <= 1'b0;
        end else if ((r_state == ST_PLAY) && i_collision) begin
            r_hit_seen <= 1'b1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_frame_cnt  <= '0;
            r_move_pulse <= 1'b0;
            r_game_rst   <= 1'b1;
            r_freeze     <= 1'b0;
            r_flash      <= 1'b0;
            r_high_score <= '0;
        end else begin
            r_state      <= w_state_next;
            r_frame_cnt  <= w_frame_cnt_next;
            r_move_pulse <= w_move_next;
            r_game_rst   <= w_rst_next;
            r_freeze     <= w_freeze_next;
            r_flash      <= w_flash_next;
            r_high_score <= w_high_score_next;
        end
    end

    // Next state and next output values; presses in IDLE/OVER start play and are not forwarded.
    always_comb begin
        w_state_next      = r_state;
        w_frame_cnt_next  = r_frame_cnt;
        w_move_next       = 1'b0;
        w_rst_next        = 1'b0;
        w_freeze_next     = 1'b0;
        w_flash_next      = 1'b0;
        w_high_score_next = r_high_score;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_state_next = ST_PLAY;
                end else begin
                    w_rst_next   = 1'b1;
                end
            end
            ST_PLAY: begin
                w_move_next = w_press;
                if (w_hit_now) begin
                    w_state_next     = ST_HIT;
                    w_frame_cnt_next = '0;
                    w_freeze_next    = 1'b1;
                    if (i_score > r_high_score) begin
                        w_high_score_next = i_score;
                    end
                end
            end
            ST_HIT: begin
                w_freeze_next = 1'b1;
                w_flash_next  = r_flash;
                if (i_frame_tick) begin
                    if (r_frame_cnt == FRM_LAST) begin
                        w_state_next = ST_OVER;
                        w_flash_next = 1'b0;
                    end else begin
                        w_frame_cnt_next = w_cnt_inc;
                        w_flash_next     = w_flash_bit;
                    end
                end
            end
            ST_OVER: begin
                if (w_press) begin
                    w_state_next = ST_PLAY;
                    w_rst_next   = 1'b1;
                end else begin
                    w_freeze_next = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_rst_next   = 1'b1;
            end
        endcase
    end

    assign o_move_pulse = r_move_pulse;
    assign o_game_rst   = r_game_rst;
    assign o_freeze     = r_freeze;
    assign o_flash      = r_flash;
    assign o_state      = r_state;
    assign o_high_score = r_high_score;

endmodule
